// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: saves the return PC, masks interrupts and
// vectors fetch on entry, then restores in-service/enable state and EPC on eret.
module int_sequencer #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        int_req,
    input  logic [2:0]  ints,
    input  logic [2:0]  irs,
    input  logic [31:0] epc,
    input  logic        safe,
    input  logic        eret,
    input  logic [31:0] pc_ret,
    output logic [2:0]  irs_w_mask,
    output logic        irs_set_en,
    output logic        irs_clr_en,
    output logic        ie_w_en,
    output logic        ie_w_data,
    output logic        epc_w_en,
    output logic [31:0] epc_w_data,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        stall
);

    // state  | meaning
    // IDLE   | normal execution, watching for eret / taken interrupt
    // SAVE   | write EPC, clear IE, set in-service bit for the level
    // VECTOR | redirect fetch to the level's handler
    // RET    | clear highest in-service bit, set IE, redirect to EPC
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  lvl_q, lvl_d;
    logic [31:0] ret_pc_q, ret_pc_d;

    logic [2:0]  set_mask;
    logic [2:0]  clr_mask;
    logic [31:0] vec_addr;

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        ret_pc_d = ret_pc_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    // eret wins over a simultaneous interrupt request
                    if (eret) begin
                        state_d = RET;
                    end else if (int_req && safe && (ints != 3'd0)) begin
                        state_d  = SAVE;
                        lvl_d    = ints;
                        ret_pc_d = pc_ret;
                    end
                end
                SAVE:    state_d = VECTOR;
                VECTOR:  state_d = IDLE;
                RET:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lvl_q    <= 3'd0;
            ret_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    always_comb begin
        set_mask = 3'b001 << (lvl_q - 3'd1);
        vec_addr = VEC_BASE + ({29'd0, lvl_q} * VEC_STRIDE);
        if (irs[2])      clr_mask = 3'b011;
        else if (irs[1]) clr_mask = 3'b101;
        else if (irs[0]) clr_mask = 3'b110;
        else             clr_mask = 3'b111;
    end

    // Outputs decode from state and latched registers; en low suppresses everything but stall.
    always_comb begin
        irs_w_mask  = 3'b000;
        irs_set_en  = 1'b0;
        irs_clr_en  = 1'b0;
        ie_w_en     = 1'b0;
        ie_w_data   = 1'b0;
        epc_w_en    = 1'b0;
        epc_w_data  = 32'd0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        stall       = (state_q != IDLE);
        if (en) begin
            case (state_q)
                SAVE: begin
                    epc_w_en   = 1'b1;
                    epc_w_data = ret_pc_q;
                    ie_w_en    = 1'b1;
                    ie_w_data  = 1'b0;
                    irs_set_en = 1'b1;
                    irs_w_mask = set_mask;
                end
                VECTOR: begin
                    pc_redirect = 1'b1;
                    pc_target   = vec_addr;
                end
                RET: begin
                    irs_clr_en  = 1'b1;
                    irs_w_mask  = clr_mask;
                    ie_w_en     = 1'b1;
                    ie_w_data   = 1'b1;
                    pc_redirect = 1'b1;
                    pc_target   = epc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: a pending-phase list model predicts each
// busy cycle's outputs; a monitor pops and compares whenever the DUT is active.
module tb_int_sequencer;

    localparam logic [31:0] VB = 32'h0000_0100;
    localparam logic [31:0] VS = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, int_req = 1'b0, safe = 1'b0, eret = 1'b0;
    logic [2:0]  ints = 3'd0, irs = 3'd0;
    logic [31:0] epc = 32'd0, pc_ret = 32'd0;
    logic [2:0]  irs_w_mask;
    logic        irs_set_en, irs_clr_en, ie_w_en, ie_w_data, epc_w_en, pc_redirect, stall;
    logic [31:0] epc_w_data, pc_target;

    int_sequencer #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .int_req(int_req), .ints(ints), .irs(irs),
        .epc(epc), .safe(safe), .eret(eret), .pc_ret(pc_ret),
        .irs_w_mask(irs_w_mask), .irs_set_en(irs_set_en), .irs_clr_en(irs_clr_en),
        .ie_w_en(ie_w_en), .ie_w_data(ie_w_data), .epc_w_en(epc_w_en),
        .epc_w_data(epc_w_data), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        epc_w_en;
        logic [31:0] epc_w_data;
        logic        ie_w_en;
        logic        ie_w_data;
        logic        irs_set_en;
        logic        irs_clr_en;
        logic [2:0]  irs_w_mask;
        logic        pc_redirect;
        logic [31:0] pc_target;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } sb_t;

    // kind: 0 = save, 1 = vector, 2 = return
    typedef struct {
        int          kind;
        int          lvl;
        logic [31:0] pc;
    } phase_t;

    sb_t    sb_q[$];
    phase_t phases[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic out_t dut_out();
        out_t d;
        d.stall       = stall;
        d.epc_w_en    = epc_w_en;
        d.epc_w_data  = epc_w_data;
        d.ie_w_en     = ie_w_en;
        d.ie_w_data   = ie_w_data;
        d.irs_set_en  = irs_set_en;
        d.irs_clr_en  = irs_clr_en;
        d.irs_w_mask  = irs_w_mask;
        d.pc_redirect = pc_redirect;
        d.pc_target   = pc_target;
        return d;
    endfunction

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic e, input logic ir, input logic [2:0] in_ints,
                        input logic [2:0] in_irs, input logic [31:0] in_epc,
                        input logic sf, input logic er, input logic [31:0] pcr);
        out_t   x;
        sb_t    s;
        phase_t p;
        @(negedge clk);
        cyc++;
        en = e; int_req = ir; ints = in_ints; irs = in_irs; epc = in_epc;
        safe = sf; eret = er; pc_ret = pcr;
        #1;
        x = '0;
        if (phases.size() != 0) begin
            x.stall = 1'b1;
            if (e) begin
                p = phases[0];
                if (p.kind == 0) begin
                    x.epc_w_en   = 1'b1;
                    x.epc_w_data = p.pc;
                    x.ie_w_en    = 1'b1;
                    x.irs_set_en = 1'b1;
                    x.irs_w_mask = 3'(1 << (p.lvl - 1));
                end else if (p.kind == 1) begin
                    x.pc_redirect = 1'b1;
                    x.pc_target   = VB + 32'(p.lvl) * VS;
                end else begin
                    x.irs_clr_en = 1'b1;
                    x.irs_w_mask = 3'b111;
                    for (int k = 0; k < 3; k++)
                        if (in_irs[k]) x.irs_w_mask = ~(3'(1 << k));
                    x.ie_w_en     = 1'b1;
                    x.ie_w_data   = 1'b1;
                    x.pc_redirect = 1'b1;
                    x.pc_target   = in_epc;
                end
            end
            s.cyc = cyc;
            s.o   = x;
            sb_q.push_back(s);
        end
        if (e) begin
            if (phases.size() != 0) begin
                void'(phases.pop_front());
            end else if (er) begin
                p.kind = 2; p.lvl = 0; p.pc = 32'd0;
                phases.push_back(p);
            end else if (ir && sf && in_ints != 3'd0) begin
                p.kind = 0; p.lvl = int'(in_ints); p.pc = pcr;
                phases.push_back(p);
                p.kind = 1;
                phases.push_back(p);
            end
        end
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: compares against the scoreboard whenever the DUT shows any activity.
    initial begin
        out_t d;
        sb_t  s;
        forever begin
            @(negedge clk);
            #2;
            d = dut_out();
            if (d != '0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected cyc=%0d got %h expected no activity", cyc, d);
                end else begin
                    s = sb_q.pop_front();
                    if (s.cyc != cyc || s.o != d) begin
                        n_fail++;
                        $display("FAIL sb_out cyc=%0d got %h expected cyc=%0d %h", cyc, d, s.cyc, s.o);
                    end
                end
            end
        end
    end

    initial begin
        #3;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_outs", 32'(dut_out() != '0), 32'd0);
        #10 rst_n = 1'b1;

        // entry at level 2
        step(1'b1, 1'b1, 3'd2, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_4008);
        idle_step();
        chk("save_epc_data", epc_w_data, 32'h0000_4008);
        chk("save_mask", 32'(irs_w_mask), 32'b010);
        chk("save_ie", 32'({ie_w_en, ie_w_data}), 32'b10);
        idle_step();
        chk("vector_target", pc_target, 32'h0000_0120);
        idle_step();
        chk("vector_done_idle", 32'(stall), 32'd0);

        // return with irs=110
        step(1'b1, 1'b0, 3'd0, 3'b110, 32'h0000_4008, 1'b0, 1'b1, 32'd0);
        step(1'b1, 1'b0, 3'd0, 3'b110, 32'h0000_4008, 1'b0, 1'b0, 32'd0);
        chk("ret_mask", 32'(irs_w_mask), 32'b011);
        chk("ret_target", pc_target, 32'h0000_4008);
        chk("ret_ie", 32'({ie_w_en, ie_w_data}), 32'b11);
        idle_step();
        chk("ret_done_idle", 32'(stall), 32'd0);

        // eret beats int_req on the same edge
        step(1'b1, 1'b1, 3'd3, 3'b100, 32'h0000_0abc, 1'b1, 1'b1, 32'h0000_5000);
        step(1'b1, 1'b0, 3'd0, 3'b100, 32'h0000_0abc, 1'b0, 1'b0, 32'd0);
        chk("prio_clr", 32'(irs_clr_en), 32'd1);
        chk("prio_no_epc", 32'(epc_w_en), 32'd0);
        idle_step();

        // int_req held while unsafe
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 3'd1, 3'd0, 32'd0, 1'b0, 1'b0, 32'h0000_6000);
            chk("unsafe_idle", 32'(stall), 32'd0);
        end
        step(1'b1, 1'b1, 3'd1, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_6000);
        idle_step();
        chk("safe_save", 32'(irs_set_en), 32'd1);
        idle_step();
        idle_step();

        // en low while in SAVE
        step(1'b1, 1'b1, 3'd3, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_7000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 32'd0);
            chk("frozen_stall_nostrobe", 32'({stall, irs_set_en, epc_w_en}), 32'b100);
        end
        idle_step();
        chk("unfrozen_save", 32'(irs_set_en), 32'd1);
        idle_step();
        chk("unfrozen_vector", pc_target, 32'h0000_0130);

        // async reset during VECTOR
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_redirect", 32'(pc_redirect), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        phases.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_8000);
            chk("ints0_idle", 32'(stall), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 4) == 0), $urandom);
        end
        for (int i = 0; i < 6; i++) idle_step();
        @(negedge clk);
        #5;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
